// File: rtl/reram_wb_bank_ctrl.sv
// reram_wb_bank_ctrl
// Wishbone classic slave that fans one bus port out to NUM_BANKS ReRAM macros.
// The bank index is decoded from wbs_adr_i[BANK_SEL_LSB +: BW]. Exactly one
// EN/R_WB transaction is issued to that bank, and the bank's func_ack is
// turned into a single-cycle wbs_ack_o.
// Optional build macro: RERAM_WB_TIMEOUT_EN. When it is defined, a bank that
// does not acknowledge within TIMEOUT_CYCLES busy cycles is abandoned, and
// the abandoned transfer is reported with wbs_err_o.
module reram_wb_bank_ctrl #(
  parameter int NUM_BANKS      = 4,
  parameter int BANK_SEL_LSB   = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_BANKS-1:0]    en_o,
  output logic                    r_wb_o,
  output logic [31:0]             di_o,
  output logic [31:0]             ad_o,
  output logic [3:0]              sel_o,
  input  logic [32*NUM_BANKS-1:0] do_i,
  input  logic [NUM_BANKS-1:0]    func_ack_i
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam logic [31:0] BANK_MASK = ~(32'(NUM_BANKS - 1) << BANK_SEL_LSB);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bank_q, bank_d;
  logic [BW-1:0]         req_bank;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [NUM_BANKS-1:0]  en_q, en_d;
  logic                  r_wb_q, r_wb_d;
  logic [31:0]           di_q, di_d;
  logic [31:0]           ad_q, ad_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           bank_do [NUM_BANKS];

`ifdef RERAM_WB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;
`else
  // Out-of-range timeout settings leave a clearly named marker block in elaboration.
  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_illegal_timeout_cycles
    end
  endgenerate
`endif

  assign req_bank = wbs_adr_i[BANK_SEL_LSB +: BW];

  generate
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank_do
      assign bank_do[g] = do_i[32*g +: 32];
    end
  endgenerate

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    en_d    = en_q;
    r_wb_d  = r_wb_q;
    di_d    = di_q;
    ad_d    = ad_q;
    sel_d   = sel_q;
`ifdef RERAM_WB_TIMEOUT_EN
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          bank_d  = req_bank;
          r_wb_d  = ~wbs_we_i;
          di_d    = wbs_dat_i;
          ad_d    = wbs_adr_i & BANK_MASK;
          sel_d   = wbs_sel_i;
          en_d    = NUM_BANKS'(1) << req_bank;
`ifdef RERAM_WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A master that abandons the cycle gets no response. Only the selected
        // bank's acknowledge is honoured, and an acknowledge beats a timeout.
        if (!wbs_cyc_i) begin
          en_d    = '0;
          state_d = IDLE;
        end else if (func_ack_i[bank_q]) begin
          if (r_wb_q) dat_d = bank_do[bank_q];
          en_d    = '0;
          ack_d   = 1'b1;
          state_d = RESP;
        end
`ifdef RERAM_WB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TO_LIMIT) begin
            en_d    = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        en_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      bank_q  <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      en_q    <= '0;
      r_wb_q  <= 1'b1;
      di_q    <= '0;
      ad_q    <= '0;
      sel_q   <= '0;
`ifdef RERAM_WB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      r_wb_q  <= r_wb_d;
      di_q    <= di_d;
      ad_q    <= ad_d;
      sel_q   <= sel_d;
`ifdef RERAM_WB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign en_o      = en_q;
  assign r_wb_o    = r_wb_q;
  assign di_o      = di_q;
  assign ad_o      = ad_q;
  assign sel_o     = sel_q;
`ifdef RERAM_WB_TIMEOUT_EN
  assign wbs_err_o = err_q;
`else
  assign wbs_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_reram_wb_bank_ctrl.sv
// Directed testbench for reram_wb_bank_ctrl (4 banks, bank field at bit 12).
// The timeout scenario is built only when RERAM_WB_TIMEOUT_EN is defined.
module tb_reram_wb_bank_ctrl;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b0;
  logic         wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_dat_i, wbs_adr_i;
  logic         wbs_ack_o, wbs_err_o;
  logic [31:0]  wbs_dat_o;
  logic [3:0]   en_o;
  logic         r_wb_o;
  logic [31:0]  di_o, ad_o;
  logic [3:0]   sel_o;
  logic [127:0] do_i;
  logic [3:0]   func_ack_i;

  int errors = 0;
  int checks = 0;

  reram_wb_bank_ctrl #(.NUM_BANKS(4), .BANK_SEL_LSB(12), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
    .en_o(en_o), .r_wb_o(r_wb_o), .di_o(di_o), .ad_o(ad_o), .sel_o(sel_o),
    .do_i(do_i), .func_ack_i(func_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic bus_idle();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_dat_i = '0;   wbs_adr_i = '0;
    func_ack_i = 4'h0;
  endtask

  task automatic start_req(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
  endtask

  task automatic test_reset();
    bus_idle();
    do_i = '0;
    wb_rst_i = 1'b0;
    start_req(1'b1, 32'h0000_2000, 32'h1, 4'hF);
    tick(); tick();
    checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", wbs_ack_o); end
    checks++; if (wbs_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", wbs_err_o); end
    checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h want 0", wbs_dat_o); end
    checks++; if (en_o !== 4'h0) begin errors++; $display("FAIL rst_en: got %b want 0000", en_o); end
    checks++; if (r_wb_o !== 1'b1) begin errors++; $display("FAIL rst_r_wb: got %b want 1", r_wb_o); end
    checks++; if ({di_o, ad_o, sel_o} !== 68'h0) begin errors++; $display("FAIL rst_bank_side: got di=%h ad=%h sel=%h want 0", di_o, ad_o, sel_o); end
    bus_idle();
    wb_rst_i = 1'b1;
    tick();
    checks++; if (en_o !== 4'h0) begin errors++; $display("FAIL rst_release_en: got %b want 0000", en_o); end
  endtask

  // Write to bank 2, bank acknowledges in the fourth EN cycle.
  task automatic test_write();
    do_i[64 +: 32] = 32'h0000_0055;
    start_req(1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (en_o !== 4'b0100) begin errors++; $display("FAIL wr_en c%0d: got %b want 0100", c, en_o); end
      checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL wr_early_ack c%0d: got %b want 0", c, wbs_ack_o); end
      if (c == 1) begin
        checks++; if (r_wb_o !== 1'b0) begin errors++; $display("FAIL wr_r_wb: got %b want 0", r_wb_o); end
        checks++; if (ad_o !== 32'h0000_0010) begin errors++; $display("FAIL wr_ad: got %h want 00000010", ad_o); end
        checks++; if (di_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_di: got %h want deadbeef", di_o); end
        checks++; if (sel_o !== 4'hF) begin errors++; $display("FAIL wr_sel: got %h want f", sel_o); end
      end
      if (c == 4) func_ack_i = 4'b0100;
    end
    tick();
    checks++; if (wbs_ack_o !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b want 1", wbs_ack_o); end
    checks++; if (wbs_err_o !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", wbs_err_o); end
    checks++; if (en_o !== 4'h0) begin errors++; $display("FAIL wr_en_drop: got %b want 0000", en_o); end
    checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL wr_dat_kept: got %h want 0", wbs_dat_o); end
    bus_idle();
    tick();
    checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse: got %b want 0", wbs_ack_o); end
  endtask

  // Read from bank 3 while bank 1 raises a spurious acknowledge.
  task automatic test_read_spurious();
    do_i[96 +: 32] = 32'h1234_5678;
    do_i[32 +: 32] = 32'hAAAA_5555;
    start_req(1'b0, 32'h0000_3004, 32'h0, 4'hF);
    tick();
    checks++; if (en_o !== 4'b1000) begin errors++; $display("FAIL rd_en: got %b want 1000", en_o); end
    checks++; if (r_wb_o !== 1'b1) begin errors++; $display("FAIL rd_r_wb: got %b want 1", r_wb_o); end
    checks++; if (ad_o !== 32'h0000_0004) begin errors++; $display("FAIL rd_ad: got %h want 00000004", ad_o); end
    func_ack_i = 4'b0010;
    tick();
    checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rd_spurious_ack: got %b want 0", wbs_ack_o); end
    checks++; if (en_o !== 4'b1000) begin errors++; $display("FAIL rd_en_held: got %b want 1000", en_o); end
    func_ack_i = 4'b1000;
    tick();
    checks++; if (wbs_ack_o !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b want 1", wbs_ack_o); end
    checks++; if (wbs_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_dat: got %h want 12345678", wbs_dat_o); end
    bus_idle();
    tick();
    checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse: got %b want 0", wbs_ack_o); end
    checks++; if (wbs_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_dat_hold: got %h want 12345678", wbs_dat_o); end
  endtask

  // Two reads, banks 0 then 1, with immediate bank acknowledges.
  task automatic test_back_to_back();
    logic [3:0] exp_en [1:5];
    logic       exp_ack [1:5];
    exp_en[1] = 4'b0001; exp_en[2] = 4'b0000; exp_en[3] = 4'b0000; exp_en[4] = 4'b0010; exp_en[5] = 4'b0000;
    exp_ack[1] = 1'b0;   exp_ack[2] = 1'b1;   exp_ack[3] = 1'b0;   exp_ack[4] = 1'b0;   exp_ack[5] = 1'b1;
    do_i[0 +: 32]  = 32'h0BAD_0000;
    do_i[32 +: 32] = 32'h0BAD_0001;
    start_req(1'b0, 32'h0000_0008, 32'h0, 4'hF);
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++; if (en_o !== exp_en[c]) begin errors++; $display("FAIL b2b_en c%0d: got %b want %b", c, en_o, exp_en[c]); end
      checks++; if (wbs_ack_o !== exp_ack[c]) begin errors++; $display("FAIL b2b_ack c%0d: got %b want %b", c, wbs_ack_o, exp_ack[c]); end
      func_ack_i = en_o;
      if (c == 2) begin
        checks++; if (wbs_dat_o !== 32'h0BAD_0000) begin errors++; $display("FAIL b2b_dat0: got %h want 0bad0000", wbs_dat_o); end
        wbs_adr_i = 32'h0000_1008;
      end
      if (c == 5) begin
        checks++; if (wbs_dat_o !== 32'h0BAD_0001) begin errors++; $display("FAIL b2b_dat1: got %h want 0bad0001", wbs_dat_o); end
      end
    end
    bus_idle();
    tick();
  endtask

  // Master drops cyc two cycles into BUSY, then a late acknowledge arrives.
  task automatic test_abort();
    start_req(1'b0, 32'h0000_1000, 32'h0, 4'hF);
    tick();
    checks++; if (en_o !== 4'b0010) begin errors++; $display("FAIL ab_en1: got %b want 0010", en_o); end
    tick();
    checks++; if (en_o !== 4'b0010) begin errors++; $display("FAIL ab_en2: got %b want 0010", en_o); end
    bus_idle();
    tick();
    checks++; if (en_o !== 4'b0000) begin errors++; $display("FAIL ab_en_drop: got %b want 0000", en_o); end
    checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL ab_ack: got %b want 0", wbs_ack_o); end
    func_ack_i = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({wbs_ack_o, wbs_err_o, en_o} !== 6'b0) begin errors++; $display("FAIL ab_late c%0d: got ack=%b err=%b en=%b want 0", c, wbs_ack_o, wbs_err_o, en_o); end
      func_ack_i = 4'b0000;
    end
  endtask

`ifdef RERAM_WB_TIMEOUT_EN
  // Bank 2 never acknowledges; expect one err pulse after 8 busy cycles.
  task automatic test_timeout();
    int err_cnt = 0, ack_cnt = 0, err_cyc = 0;
    start_req(1'b0, 32'h0000_2000, 32'h0, 4'hF);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (wbs_err_o === 1'b1) begin err_cnt++; err_cyc = c; bus_idle(); end
      if (wbs_ack_o === 1'b1) ack_cnt++;
    end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL to_err_count: got %0d want 1", err_cnt); end
    checks++; if (err_cyc < 9 || err_cyc > 10) begin errors++; $display("FAIL to_err_cycle: got %0d want 9..10", err_cyc); end
    checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL to_ack_count: got %0d want 0", ack_cnt); end
    checks++; if (en_o !== 4'h0) begin errors++; $display("FAIL to_en: got %b want 0000", en_o); end
    checks++; if (wbs_dat_o !== 32'h0BAD_0001) begin errors++; $display("FAIL to_dat_kept: got %h want 0bad0001", wbs_dat_o); end
    start_req(1'b1, 32'h0000_0040, 32'h7777_0000, 4'h1);
    tick();
    func_ack_i = 4'b0001;
    tick();
    checks++; if ({wbs_ack_o, wbs_err_o} !== 2'b10) begin errors++; $display("FAIL to_recover: got ack=%b err=%b want ack=1 err=0", wbs_ack_o, wbs_err_o); end
    bus_idle();
    tick();
  endtask
`endif

  // Reset asserted while a write to bank 3 is busy, then a normal read.
  task automatic test_reset_mid();
    start_req(1'b1, 32'h0000_3ABC, 32'h1111_2222, 4'h3);
    tick();
    checks++; if (en_o !== 4'b1000) begin errors++; $display("FAIL rm_en: got %b want 1000", en_o); end
    #2 wb_rst_i = 1'b0;
    #1;
    checks++; if (en_o !== 4'h0) begin errors++; $display("FAIL rm_en_clear: got %b want 0000", en_o); end
    checks++; if (r_wb_o !== 1'b1) begin errors++; $display("FAIL rm_r_wb: got %b want 1", r_wb_o); end
    checks++; if ({di_o, ad_o, sel_o} !== 68'h0) begin errors++; $display("FAIL rm_bank_side: got di=%h ad=%h sel=%h want 0", di_o, ad_o, sel_o); end
    checks++; if ({wbs_ack_o, wbs_err_o, wbs_dat_o} !== 34'h0) begin errors++; $display("FAIL rm_wb_side: got ack=%b err=%b dat=%h want 0", wbs_ack_o, wbs_err_o, wbs_dat_o); end
    bus_idle();
    #1 wb_rst_i = 1'b1;
    tick();
    do_i[0 +: 32] = 32'hCAFE_F00D;
    start_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    tick();
    checks++; if (en_o !== 4'b0001 || ad_o !== 32'h20) begin errors++; $display("FAIL rm_rd_issue: got en=%b ad=%h want en=0001 ad=00000020", en_o, ad_o); end
    func_ack_i = 4'b0001;
    tick();
    checks++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rm_rd_done: got ack=%b dat=%h want ack=1 dat=cafef00d", wbs_ack_o, wbs_dat_o); end
    bus_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_spurious();
    test_back_to_back();
    test_abort();
`ifdef RERAM_WB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
